// File: rtl/pattern_detector_n_if.sv
// pattern_detector_n_if: serial-stream and status bundle for pattern_detector_n.
//   master (stream source / status sink): drives seq_in, seq_valid, pattern,
//     load, overlap, count_clear; observes seq_out, match_count, armed.
//   slave  (the detector): the mirror image.
interface pattern_detector_n_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
);
    logic             seq_in;
    logic             seq_valid;
    logic [WIDTH-1:0] pattern;
    logic             load;
    logic             overlap;
    logic             count_clear;
    logic             seq_out;
    logic [CNT_W-1:0] match_count;
    logic             armed;

    modport master (
        output seq_in, seq_valid, pattern, load, overlap, count_clear,
        input  seq_out, match_count, armed
    );

    modport slave (
        input  seq_in, seq_valid, pattern, load, overlap, count_clear,
        output seq_out, match_count, armed
    );
endinterface

// File: rtl/pattern_detector_n.sv
// pattern_detector_n: run-time programmable serial bit-pattern detector.
//   clock  : rising-edge system clock
//   reset  : asynchronous, active-low reset
//   bus    : pattern_detector_n_if slave port
//     seq_in/seq_valid : serial bit and its qualifier
//     pattern/load     : new pattern (MSB is first bit received), load strobe
//     overlap          : 1 = overlapping matches, 0 = restart after a match
//     count_clear      : synchronous clear of match_count
//     seq_out          : registered one-cycle match flag
//     match_count      : saturating match counter
//     armed            : history holds WIDTH valid bits
module pattern_detector_n #(
    parameter int unsigned     WIDTH        = 4,
    parameter logic [WIDTH-1:0] PATTERN_INIT = WIDTH'(4'b0111),
    parameter int unsigned     CNT_W        = 8
) (
    input logic               clock,
    input logic               reset,
    pattern_detector_n_if.slave bus
);
    localparam int unsigned FILL_W = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);

    logic [WIDTH-1:0]  hist_q,    hist_d;
    logic [FILL_W-1:0] fill_q,    fill_d;
    logic [WIDTH-1:0]  pattern_q, pattern_d;
    logic              seq_out_q, seq_out_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic              armed_q,   armed_d;

    logic [WIDTH:0]    shifted;
    logic [WIDTH-1:0]  hist_next;
    logic [FILL_W-1:0] fill_next;
    logic              hit;

    always_comb begin
        // Concatenate then truncate so WIDTH=1 needs no special case.
        shifted   = {hist_q, bus.seq_in};
        hist_next = shifted[WIDTH-1:0];
        fill_next = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        hit       = (fill_next == FILL_FULL) && (hist_next == pattern_q);

        hist_d    = hist_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        seq_out_d = 1'b0;

        if (bus.load) begin
            // A sample arriving with load is dropped.
            pattern_d = bus.pattern;
            hist_d    = '0;
            fill_d    = '0;
        end else if (bus.seq_valid) begin
            hist_d    = hist_next;
            seq_out_d = hit;
            fill_d    = (hit && !bus.overlap) ? '0 : fill_next;
        end

        count_d = count_q;
        if (bus.count_clear) begin
            count_d = '0;
        end else if (seq_out_d && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end

        armed_d = (fill_d == FILL_FULL);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= PATTERN_INIT;
            seq_out_q <= 1'b0;
            count_q   <= '0;
            armed_q   <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            seq_out_q <= seq_out_d;
            count_q   <= count_d;
            armed_q   <= armed_d;
        end
    end

    assign bus.seq_out     = seq_out_q;
    assign bus.match_count = count_q;
    assign bus.armed       = armed_q;
endmodule

// File: doc/pattern_detector_n.md
Name: pattern_detector_n

Overview:
Parametrised serial bit-pattern detector. This is the run-time-programmable, width-generic successor to the fixed "0111" Moore recogniser. It watches a serial bit stream that has a qualifying valid strobe. On the cycle after the last WIDTH received bits equal a loadable pattern, it raises a registered one-cycle match flag. It sits between the serial input front-end and the status/interrupt logic, and keeps a saturating match counter for software.

Parameters:
WIDTH, 4, pattern length in bits; legal range 1..16.
PATTERN_INIT, 4'b0111 (WIDTH bits), pattern value held after reset.
CNT_W, 8, width of match_count.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
seq_in  input  1  serial data bit, sampled only when seq_valid=1.
seq_valid  input  1  qualifies seq_in for the current cycle.
pattern  input  WIDTH  new pattern value, captured when load=1. pattern[WIDTH-1] is the first bit received.
load  input  1  one-cycle strobe: latch pattern and flush the history.
overlap  input  1  1 = overlapping matches allowed; 0 = history restarts after each match.
count_clear  input  1  synchronous clear of match_count.
seq_out  output  1  registered match flag; high for exactly one cycle per match.
match_count  output  CNT_W  number of matches; saturates at all-ones.
armed  output  1  high when the history holds WIDTH valid bits (fill == WIDTH).

Behaviour:
- Reset (reset=0, asynchronous):
  - hist=0, fill=0, pattern_reg=PATTERN_INIT.
  - seq_out=0, match_count=0, armed=0.
  - Outputs take these values without waiting for a clock edge.
  - After release, state changes only on rising edges of clock.
- State registers:
  - hist[WIDTH-1:0] is a shift register; the newest bit is at the LSB.
  - fill is a counter 0..WIDTH, ceil(log2(WIDTH+1)) bits.
  - pattern_reg[WIDTH-1:0] holds the active pattern.
- Accepted sample (seq_valid=1 and load=0):
  - hist_next = {hist[WIDTH-2:0], seq_in}; for WIDTH=1, hist_next = seq_in.
  - fill_next = min(fill+1, WIDTH).
  - hit = (fill_next == WIDTH) and (hist_next == pattern_reg).
  - Register seq_out <= hit, and hist <= hist_next.
  - If hit and overlap=0, fill <= 0; otherwise fill <= fill_next.
- No accepted sample (seq_valid=0, load=0): hist and fill hold; seq_out <= 0.
- Latency: seq_out rises on the clock edge following the edge that sampled the completing bit. This is Moore-style: never combinational from seq_in.
- fill gating: no match is possible until WIDTH bits have been accepted since reset, load, or a non-overlap match. A zero-initialised history therefore never false-matches.
- Load (load=1):
  - pattern_reg <= pattern, hist <= 0, fill <= 0, seq_out <= 0.
  - A seq_valid sample in the same cycle is discarded (load wins).
  - match_count is unaffected.
- overlap is sampled each accepted cycle. Changing it never alters hist or fill by itself.
- match_count:
  - Increments by 1 on each cycle a hit is registered.
  - Saturates at 2^CNT_W-1 and never wraps.
  - count_clear=1 sets it to 0; clear takes priority over a simultaneous hit, giving 0.
- armed is a registered view of (fill == WIDTH).
- Reset mid-stream: partial history is lost, and a pending seq_out is cleared immediately.

Test Plan:
- Reset; default pattern 0111, overlap=1; feed 0,1,1,1 with seq_valid=1 -> seq_out=1 for one cycle, on the edge after the 4th bit; match_count=1.
- Reset; feed 1,1,1 -> seq_out stays 0 and armed=0 (fill gating). Then feed 0,1,1,1 -> one match.
- load pattern=4'b1010, overlap=1; feed 1,0,1,0,1,0 -> seq_out pulses after bits 4 and 6; match_count=2. Repeat with overlap=0 -> one pulse, after bit 4; match_count=1.
- Pattern 0111; feed 0,1, then seq_valid=0 for 3 cycles, then 1,1 -> seq_out=0 during the gap and one pulse after the final bit. Assert load together with seq_valid on the 3rd bit -> no match, history flushed, armed=0.
- CNT_W=2; produce 5 matches -> match_count saturates at 3. Assert count_clear in the same cycle as a hit -> match_count=0.
- Feed 0,1,1, then pull reset low for 2 ns between edges -> seq_out=0 and match_count=0 immediately. After release, feed 1 -> no match.
